filter_pair_arbiter: RTL and testbench

// Sits directly downstream of the NUM_FILTERS planar filter lanes of one cell's force unit.

---
 rtl/filter_pair_arbiter.sv | 158 +++++++++++++++
 tb/tb_filter_pair_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_pair_arbiter.sv
// Collects per-lane filter pairs into small FIFOs and drains them round-robin
// into a single registered valid/ready stream feeding the force pipeline.
module filter_pair_arbiter #(
    parameter int NUM_FILTERS  = 4,
    parameter int DEPTH        = 8,
    parameter int PAIR_W       = 96,
    parameter int AFULL_THRESH = 6,
    localparam int LANE_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_FILTERS-1:0]        filter_pass,
    input  logic [NUM_FILTERS*PAIR_W-1:0] filter_pair,
    output logic [NUM_FILTERS-1:0]        filter_stall,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PAIR_W-1:0]             out_pair,
    output logic [LANE_W-1:0]             out_lane,
    output logic                          overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_t;

    out_state_t              state_q;
    logic [PAIR_W-1:0]       out_pair_q;
    logic [LANE_W-1:0]       out_lane_q;
    logic [LANE_W-1:0]       rr_q;
    logic                    overflow_q;

    logic [PAIR_W-1:0]       mem_q    [NUM_FILTERS][DEPTH];
    logic [AW-1:0]           wr_ptr_q [NUM_FILTERS];
    logic [AW-1:0]           rd_ptr_q [NUM_FILTERS];
    logic [CW-1:0]           count_q  [NUM_FILTERS];
    logic [CW-1:0]           count_d  [NUM_FILTERS];

    logic [NUM_FILTERS-1:0]  push;
    logic [NUM_FILTERS-1:0]  pop;
    logic [NUM_FILTERS-1:0]  not_empty;
    logic [NUM_FILTERS-1:0]  lane_full;
    logic [LANE_W-1:0]       grant;
    logic [LANE_W-1:0]       rr_d;
    logic                    grant_vld;
    logic                    load;
    logic                    do_grant;

    // Full is judged on the count before this cycle's pop, so a push into a
    // full lane is dropped even when that lane is being drained this edge.
    always_comb begin
        for (int i = 0; i < NUM_FILTERS; i++) begin
            not_empty[i]    = (count_q[i] != '0);
            lane_full[i]    = (count_q[i] == CW'(DEPTH));
            push[i]         = filter_pass[i] && !lane_full[i];
            filter_stall[i] = (count_q[i] >= CW'(AFULL_THRESH));
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            idx = (int'(rr_q) + k) % NUM_FILTERS;
            if (!grant_vld && not_empty[idx]) begin
                grant_vld = 1'b1;
                grant     = LANE_W'(idx);
            end
        end
    end

    always_comb begin
        load     = (state_q == OUT_EMPTY) || out_ready;
        do_grant = load && grant_vld;
        rr_d     = (grant == LANE_W'(NUM_FILTERS - 1)) ? '0 : grant + 1'b1;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            pop[i]     = do_grant && (grant == LANE_W'(i));
            count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    // Payload storage carries no reset; only pointers and counts decide validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= filter_pair[i*PAIR_W +: PAIR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                end
                count_q[i] <= count_d[i];
            end
            if (|(filter_pass & lane_full)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Output register: reloads on the same edge it is consumed, giving one pair per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OUT_EMPTY;
            out_pair_q <= '0;
            out_lane_q <= '0;
            rr_q       <= '0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (grant_vld) begin
                        out_pair_q <= mem_q[grant][rd_ptr_q[grant]];
                        out_lane_q <= grant;
                        rr_q       <= rr_d;
                        state_q    <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (out_ready) begin
                        if (grant_vld) begin
                            out_pair_q <= mem_q[grant][rd_ptr_q[grant]];
                            out_lane_q <= grant;
                            rr_q       <= rr_d;
                        end else begin
                            state_q <= OUT_EMPTY;
                        end
                    end
                end
                default: state_q <= OUT_EMPTY;
            endcase
        end
    end

    assign out_valid = (state_q == OUT_FULL);
    assign out_pair  = out_pair_q;
    assign out_lane  = out_lane_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_filter_pair_arbiter.sv
// Directed bench for filter_pair_arbiter: latency, round-robin order, stall,
// overflow, mid-run reset and output hold under backpressure.
module tb_filter_pair_arbiter;

    localparam int N  = 4;
    localparam int PW = 96;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    filter_pass;
    logic [N*PW-1:0] filter_pair;
    logic [N-1:0]    filter_stall;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   out_pair;
    logic [1:0]      out_lane;
    logic            overflow;

    int vectorCount = 0;
    int miscompares = 0;

    filter_pair_arbiter #(
        .NUM_FILTERS (N),
        .DEPTH       (8),
        .PAIR_W      (PW),
        .AFULL_THRESH(6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .filter_pass (filter_pass),
        .filter_pair (filter_pair),
        .filter_stall(filter_stall),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pair    (out_pair),
        .out_lane    (out_lane),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [PW-1:0] observed,
                               input logic [PW-1:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] pass, input logic [PW-1:0] p0,
                                 input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                                 input logic [PW-1:0] p3);
        filter_pass = pass;
        filter_pair = {p3, p2, p1, p0};
    endtask

    task automatic applyReset;
        rst = 1'b1;
        applyStimulus(4'b0000, '0, '0, '0, '0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        int g;
        out_ready = 1'b1;
        applyReset();

        // Reset state
        checkOutput("rst valid", PW'(out_valid), PW'(0));
        checkOutput("rst pair", out_pair, PW'(0));
        checkOutput("rst lane", PW'(out_lane), PW'(0));
        checkOutput("rst stall", PW'(filter_stall), PW'(0));
        checkOutput("rst ovf", PW'(overflow), PW'(0));

        // Single pass on lane 2: visible two edges later for one cycle
        applyStimulus(4'b0100, '0, '0, 96'hABC, '0);
        tick();
        applyStimulus(4'b0000, '0, '0, '0, '0);
        checkOutput("t1 valid t+1", PW'(out_valid), PW'(0));
        tick();
        checkOutput("t1 valid t+2", PW'(out_valid), PW'(1));
        checkOutput("t1 pair", out_pair, 96'hABC);
        checkOutput("t1 lane", PW'(out_lane), PW'(2));
        tick();
        checkOutput("t1 valid after", PW'(out_valid), PW'(0));

        // All four lanes at once: drained 0,1,2,3
        applyReset();
        applyStimulus(4'b1111, 96'd10, 96'd11, 96'd12, 96'd13);
        tick();
        applyStimulus(4'b0000, '0, '0, '0, '0);
        for (int j = 0; j < 4; j++) begin
            tick();
            checkOutput("t2 valid", PW'(out_valid), PW'(1));
            checkOutput("t2 lane", PW'(out_lane), PW'(j));
            checkOutput("t2 pair", out_pair, PW'(10 + j));
        end
        tick();
        checkOutput("t2 valid end", PW'(out_valid), PW'(0));

        // Backpressure on lane 0: output reg takes entry 0, FIFO fills with 1..8, entry 9 dropped
        applyReset();
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(4'b0001, PW'(k - 1), '0, '0, '0);
            tick();
            cnt = (k == 1) ? 1 : ((k <= 9) ? k - 1 : 8);
            checkOutput("t3 stall", PW'(filter_stall[0]), PW'(cnt >= 6));
            checkOutput("t3 ovf", PW'(overflow), PW'(k == 10));
            if (k >= 2) checkOutput("t3 held pair", out_pair, PW'(0));
        end
        applyStimulus(4'b0000, '0, '0, '0, '0);
        out_ready = 1'b1;
        for (int v = 0; v <= 8; v++) begin
            checkOutput("t3 drain valid", PW'(out_valid), PW'(1));
            checkOutput("t3 drain pair", out_pair, PW'(v));
            tick();
        end
        checkOutput("t3 drain end", PW'(out_valid), PW'(0));
        checkOutput("t3 ovf sticky", PW'(overflow), PW'(1));
        checkOutput("t3 stall clear", PW'(filter_stall), PW'(0));

        // Lanes 1 and 3 continuously: strict alternation 1,3,1,3
        applyReset();
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(4'b1010, '0, PW'(32'h100 + c), '0, PW'(32'h300 + c));
            tick();
            if (c >= 1) begin
                g = c - 1;
                checkOutput("t4 lane", PW'(out_lane), PW'((g % 2 == 0) ? 1 : 3));
                checkOutput("t4 pair", out_pair,
                            PW'(((g % 2 == 0) ? 32'h100 : 32'h300) + g / 2));
            end
        end

        // Mid-run reset with stall and overflow raised
        applyReset();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(4'b0001, PW'(c), '0, '0, '0);
            tick();
        end
        applyStimulus(4'b0000, '0, '0, '0, '0);
        checkOutput("t5 pre valid", PW'(out_valid), PW'(1));
        checkOutput("t5 pre stall", PW'(filter_stall[0]), PW'(1));
        checkOutput("t5 pre ovf", PW'(overflow), PW'(1));
        applyReset();
        checkOutput("t5 valid", PW'(out_valid), PW'(0));
        checkOutput("t5 stall", PW'(filter_stall), PW'(0));
        checkOutput("t5 ovf", PW'(overflow), PW'(0));
        out_ready = 1'b1;
        applyStimulus(4'b0010, '0, 96'h55, '0, '0);
        tick();
        applyStimulus(4'b0000, '0, '0, '0, '0);
        checkOutput("t5 new t+1", PW'(out_valid), PW'(0));
        tick();
        checkOutput("t5 new valid", PW'(out_valid), PW'(1));
        checkOutput("t5 new pair", out_pair, 96'h55);
        checkOutput("t5 new lane", PW'(out_lane), PW'(1));
        tick();
        checkOutput("t5 no stale", PW'(out_valid), PW'(0));

        // Output held under out_ready=0 while lanes 0 and 2 keep pushing
        applyReset();
        out_ready = 1'b1;
        applyStimulus(4'b0101, 96'hA0, '0, 96'hC0, '0);
        tick();
        applyStimulus(4'b0101, 96'hA1, '0, 96'hC1, '0);
        tick();
        checkOutput("t6 first pair", out_pair, 96'hA0);
        out_ready = 1'b0;
        for (int j = 2; j <= 4; j++) begin
            applyStimulus(4'b0101, PW'(8'hA0 + j), '0, PW'(8'hC0 + j), '0);
            tick();
            checkOutput("t6 hold valid", PW'(out_valid), PW'(1));
            checkOutput("t6 hold pair", out_pair, 96'hA0);
            checkOutput("t6 hold lane", PW'(out_lane), PW'(0));
        end
        applyStimulus(4'b0000, '0, '0, '0, '0);
        out_ready = 1'b1;
        for (int m = 0; m < 9; m++) begin
            tick();
            checkOutput("t6 drain lane", PW'(out_lane), PW'((m % 2 == 0) ? 2 : 0));
            checkOutput("t6 drain pair", out_pair,
                        PW'((m % 2 == 0) ? (8'hC0 + m / 2) : (8'hA0 + (m + 1) / 2)));
        end
        tick();
        checkOutput("t6 drain end", PW'(out_valid), PW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
